// File: rtl/ts_null_inserter_pkg.sv
// ts_null_inserter_pkg
//   Shared constants, state encodings and helpers for the TS null-packet
//   inserter.
//   Contents:
//     - TS packet geometry: length, last byte index and sync byte.
//     - Null-packet header bytes and the stuffing byte.
//     - Read and write FSM state encodings.
//     - null_byte(): the byte at a given index of a null packet.
package ts_null_inserter_pkg;

  localparam int          BYTE_W      = 8;
  localparam logic [7:0]  TS_PKT_LEN  = 8'd188;
  localparam logic [7:0]  TS_LAST_IDX = 8'd187;
  localparam logic [7:0]  TS_SYNC     = 8'h47;
  localparam logic [12:0] NULL_PID    = 13'h1FFF;
  localparam logic [7:0]  STUFF_BYTE  = 8'hFF;

  // Null header: no TEI/PUSI/priority, PID 0x1FFF, payload only, CC fixed at 0.
  localparam logic [7:0] NULL_HDR1 = {3'b000, NULL_PID[12:8]};
  localparam logic [7:0] NULL_HDR2 = NULL_PID[7:0];
  localparam logic [7:0] NULL_HDR3 = 8'h10;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_PKT  = 2'd1,
    RD_NULL = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_HUNT = 2'd0,
    WR_FILL = 2'd1,
    WR_DROP = 2'd2
  } wr_state_t;

  function automatic logic [7:0] null_byte(input logic [7:0] idx);
    logic [7:0] b;
    case (idx)
      8'd0:    b = TS_SYNC;
      8'd1:    b = NULL_HDR1;
      8'd2:    b = NULL_HDR2;
      8'd3:    b = NULL_HDR3;
      default: b = STUFF_BYTE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ts_null_inserter_ram.sv
// ts_pkt_ram
//   Simple dual-port byte RAM, one write port and one read port, with a
//   registered read (data appears the cycle after rd_en). No reset on the
//   storage or the read register so it maps onto block RAM.
//   Ports:
//     CLK      clock
//     wr_en    write strobe
//     wr_addr  write address
//     wr_data  write byte
//     rd_en    read strobe, updates rd_data on the next edge
//     rd_addr  read address
//     rd_data  registered read byte
module ts_pkt_ram
  import ts_null_inserter_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [BYTE_W-1:0] rd_data
);

  logic [BYTE_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ts_null_inserter.sv
// ts_null_inserter
//   Buffers bursty 188-byte TS packets from the T2-MI packer into a ring of
//   DEPTH_PKTS packets and replays them at one byte per TICK. Whenever no
//   complete packet is buffered at a packet boundary a null packet
//   (PID 0x1FFF) is emitted instead, keeping the output stream continuous.
//   Ports:
//     CLK, RST    clock, asynchronous active-high reset
//     DATA_IN     input TS byte, valid with ENA_IN
//     PSYNC_IN    marks the sync byte of each input packet
//     TICK        output byte-rate strobe (>= 3 cycles apart)
//     DATA_OUT    output TS byte, valid with ENA_OUT (2 cycles after TICK)
//     PSYNC_OUT   marks byte 0 of each output packet
//     pkt_count   complete packets buffered and not yet started
//     ovf_count   dropped input packets, saturating at 255
//     state_mon   read FSM state
module ts_null_inserter
  import ts_null_inserter_pkg::*;
#(
  parameter int DEPTH_PKTS = 4,
  parameter int ADDR_W     = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DATA_IN,
  input  logic       ENA_IN,
  input  logic       PSYNC_IN,
  input  logic       TICK,
  output logic [7:0] DATA_OUT,
  output logic       ENA_OUT,
  output logic       PSYNC_OUT,
  output logic [2:0] pkt_count,
  output logic [7:0] ovf_count,
  output logic [1:0] state_mon
);

  localparam int                RING     = DEPTH_PKTS * int'(TS_PKT_LEN);
  localparam logic [ADDR_W:0]   RING_W   = (ADDR_W+1)'(RING);
  localparam logic [2:0]        FULL_CNT = 3'(DEPTH_PKTS);

  // Ring arithmetic: the buffer is DEPTH_PKTS*188 bytes, not a power of two,
  // so every pointer step folds back explicitly.
  function automatic logic [ADDR_W-1:0] ring_add(input logic [ADDR_W-1:0] base,
                                                 input logic [7:0]        off);
    logic [ADDR_W:0] sum;
    sum = {1'b0, base} + (ADDR_W+1)'(off);
    if (sum >= RING_W) begin
      sum = sum - RING_W;
    end
    return sum[ADDR_W-1:0];
  endfunction

  // ---------------------------------------------------------------- write side
  wr_state_t         wr_state_reg, wr_state_next;
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] pkt_start_reg;
  logic [7:0]        wr_cnt_reg, wr_cnt_next;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              commit;
  logic              ovf_hit;
  logic              in_sync;

  // ----------------------------------------------------------------- read side
  rd_state_t         rd_state_reg, rd_state_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [7:0]        rd_byte_reg, rd_byte_next;
  logic              rd_start;
  logic              ram_re;
  logic [ADDR_W-1:0] rd_addr;
  logic              emit;
  logic              emit_null;
  logic [7:0]        ram_q;

  logic [2:0]        pkt_count_reg;
  logic [7:0]        ovf_count_reg;

  // Output pipeline: stage 1 lines up with the RAM read register, stage 2 is
  // the output register.
  logic              p1_valid_reg, p1_psync_reg, p1_null_reg;
  logic [7:0]        p1_data_reg;
  logic [7:0]        data_out_reg;
  logic              ena_out_reg, psync_out_reg;

  assign in_sync = ENA_IN & PSYNC_IN;

  always_comb begin
    wr_state_next = wr_state_reg;
    wr_ptr_next   = wr_ptr_reg;
    wr_cnt_next   = wr_cnt_reg;
    wr_en         = 1'b0;
    wr_addr       = wr_ptr_reg;
    commit        = 1'b0;
    ovf_hit       = 1'b0;
    case (wr_state_reg)
      WR_HUNT, WR_DROP: begin
        // Outside FILL, wr_ptr always equals pkt_start.
        if (in_sync) begin
          if (pkt_count_reg == FULL_CNT) begin
            wr_state_next = WR_DROP;
            ovf_hit       = 1'b1;
          end else begin
            wr_en         = 1'b1;
            wr_addr       = wr_ptr_reg;
            wr_ptr_next   = ring_add(wr_ptr_reg, 8'd1);
            wr_cnt_next   = 8'd1;
            wr_state_next = WR_FILL;
          end
        end
      end
      WR_FILL: begin
        if (in_sync) begin
          // Early sync: drop the partial packet and restart at its base,
          // writing the new sync byte in the same cycle.
          wr_en       = 1'b1;
          wr_addr     = pkt_start_reg;
          wr_ptr_next = ring_add(pkt_start_reg, 8'd1);
          wr_cnt_next = 8'd1;
        end else if (ENA_IN) begin
          wr_en       = 1'b1;
          wr_addr     = wr_ptr_reg;
          wr_ptr_next = ring_add(wr_ptr_reg, 8'd1);
          wr_cnt_next = wr_cnt_reg + 8'd1;
          if (wr_cnt_reg == TS_LAST_IDX) begin
            commit        = 1'b1;
            wr_state_next = WR_HUNT;
          end
        end
      end
      default: wr_state_next = WR_HUNT;
    endcase
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    rd_ptr_next   = rd_ptr_reg;
    rd_byte_next  = rd_byte_reg;
    rd_start      = 1'b0;
    ram_re        = 1'b0;
    emit          = 1'b0;
    emit_null     = 1'b0;
    rd_addr       = ring_add(rd_ptr_reg, rd_byte_reg);
    if (TICK) begin
      emit = 1'b1;
      case (rd_state_reg)
        RD_IDLE: begin
          // The deciding TICK already emits byte 0, so packets run back to back.
          rd_byte_next = 8'd1;
          if (pkt_count_reg != 3'd0) begin
            rd_state_next = RD_PKT;
            rd_start      = 1'b1;
            ram_re        = 1'b1;
          end else begin
            rd_state_next = RD_NULL;
            emit_null     = 1'b1;
          end
        end
        RD_PKT, RD_NULL: begin
          ram_re    = (rd_state_reg == RD_PKT);
          emit_null = (rd_state_reg == RD_NULL);
          if (rd_byte_reg == TS_LAST_IDX) begin
            rd_byte_next  = 8'd0;
            rd_state_next = RD_IDLE;
            if (rd_state_reg == RD_PKT) begin
              rd_ptr_next = ring_add(rd_ptr_reg, TS_PKT_LEN);
            end
          end else begin
            rd_byte_next = rd_byte_reg + 8'd1;
          end
        end
        default: begin
          emit          = 1'b0;
          rd_byte_next  = 8'd0;
          rd_state_next = RD_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_state_reg  <= WR_HUNT;
      wr_ptr_reg    <= '0;
      pkt_start_reg <= '0;
      wr_cnt_reg    <= 8'd0;
      rd_state_reg  <= RD_IDLE;
      rd_ptr_reg    <= '0;
      rd_byte_reg   <= 8'd0;
      pkt_count_reg <= 3'd0;
      ovf_count_reg <= 8'd0;
      p1_valid_reg  <= 1'b0;
      p1_psync_reg  <= 1'b0;
      p1_null_reg   <= 1'b0;
      p1_data_reg   <= 8'd0;
      data_out_reg  <= 8'd0;
      ena_out_reg   <= 1'b0;
      psync_out_reg <= 1'b0;
    end else begin
      wr_state_reg <= wr_state_next;
      wr_ptr_reg   <= wr_ptr_next;
      wr_cnt_reg   <= wr_cnt_next;
      if (commit) begin
        pkt_start_reg <= wr_ptr_next;
      end

      rd_state_reg <= rd_state_next;
      rd_ptr_reg   <= rd_ptr_next;
      rd_byte_reg  <= rd_byte_next;

      case ({commit, rd_start})
        2'b10:   pkt_count_reg <= pkt_count_reg + 3'd1;
        2'b01:   pkt_count_reg <= pkt_count_reg - 3'd1;
        default: pkt_count_reg <= pkt_count_reg;
      endcase

      if (ovf_hit && (ovf_count_reg != 8'hFF)) begin
        ovf_count_reg <= ovf_count_reg + 8'd1;
      end

      p1_valid_reg <= emit;
      p1_psync_reg <= emit && (rd_byte_reg == 8'd0);
      p1_null_reg  <= emit_null;
      p1_data_reg  <= null_byte(rd_byte_reg);

      ena_out_reg   <= p1_valid_reg;
      psync_out_reg <= p1_psync_reg;
      if (!p1_valid_reg) begin
        data_out_reg <= 8'd0;
      end else if (p1_null_reg) begin
        data_out_reg <= p1_data_reg;
      end else begin
        data_out_reg <= ram_q;
      end
    end
  end

  ts_pkt_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .CLK     (CLK),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (DATA_IN),
    .rd_en   (ram_re),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  assign DATA_OUT  = data_out_reg;
  assign ENA_OUT   = ena_out_reg;
  assign PSYNC_OUT = psync_out_reg;
  assign pkt_count = pkt_count_reg;
  assign ovf_count = ovf_count_reg;
  assign state_mon = rd_state_reg;

endmodule

// File: tb/tb_ts_null_inserter.sv
// tb_ts_null_inserter
//   Directed bench for ts_null_inserter: null filling, a packer-style packet
//   arriving mid-null, overflow drops, early-sync discard, stray bytes before
//   sync and reset during packet readout.
module tb_ts_null_inserter;

  logic       CLK;
  logic       RST;
  logic [7:0] DATA_IN;
  logic       ENA_IN;
  logic       PSYNC_IN;
  logic       TICK;
  logic [7:0] DATA_OUT;
  logic       ENA_OUT;
  logic       PSYNC_OUT;
  logic [2:0] pkt_count;
  logic [7:0] ovf_count;
  logic [1:0] state_mon;

  ts_null_inserter #(
    .DEPTH_PKTS (4),
    .ADDR_W     (10)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DATA_IN   (DATA_IN),
    .ENA_IN    (ENA_IN),
    .PSYNC_IN  (PSYNC_IN),
    .TICK      (TICK),
    .DATA_OUT  (DATA_OUT),
    .ENA_OUT   (ENA_OUT),
    .PSYNC_OUT (PSYNC_OUT),
    .pkt_count (pkt_count),
    .ovf_count (ovf_count),
    .state_mon (state_mon)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] d;
    logic       p;
    int         c;
  } ob_t;

  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  ob_t out_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin : mon
    ob_t ob;
    if (ENA_OUT === 1'b1) begin
      ob.d = DATA_OUT;
      ob.p = PSYNC_OUT;
      ob.c = cyc;
      out_q.push_back(ob);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] exp_null(input int i);
    logic [7:0] b;
    case (i)
      0:       b = 8'h47;
      1:       b = 8'h1F;
      2:       b = 8'hFF;
      3:       b = 8'h10;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  // Packer-style packet: 47, tag, 00, 10, then payload (k + tag) for k=0..183.
  function automatic logic [7:0] pkt_byte(input int tag, input int i);
    logic [7:0] b;
    if (i == 0)      b = 8'h47;
    else if (i == 1) b = 8'(tag);
    else if (i == 2) b = 8'h00;
    else if (i == 3) b = 8'h10;
    else             b = 8'(i - 4 + tag);
    return b;
  endfunction

  task automatic check(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=0x%0h expected=0x%0h", tag, idx, obs, exp);
    end
  endtask

  // Checks 188 captured bytes from 'start'; ptag < 0 means a null packet.
  task automatic check_pkt(input string tag, input int start, input int ptag);
    logic [7:0] e;
    for (int i = 0; i < 188; i++) begin
      if (start + i < out_q.size()) begin
        e = (ptag < 0) ? exp_null(i) : pkt_byte(ptag, i);
        check({tag, "_data"}, i, 32'(out_q[start+i].d), 32'(e));
        check({tag, "_psync"}, i, 32'(out_q[start+i].p), 32'(i == 0));
      end
    end
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      TICK = 1'b1;
      @(posedge CLK); #1;
      TICK = 1'b0;
      repeat (2) @(posedge CLK);
    end
  endtask

  // Byte 3 is followed by a 3-cycle ENA gap, like the packer's header/payload gap.
  task automatic send_pkt(input int tag, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      @(posedge CLK); #1;
      DATA_IN  = pkt_byte(tag, i);
      ENA_IN   = 1'b1;
      PSYNC_IN = (i == 0);
      if (i == 3) begin
        @(posedge CLK); #1;
        ENA_IN   = 1'b0;
        PSYNC_IN = 1'b0;
        repeat (2) @(posedge CLK);
      end
    end
    @(posedge CLK); #1;
    ENA_IN   = 1'b0;
    PSYNC_IN = 1'b0;
  endtask

  initial begin
    DATA_IN  = 8'h00;
    ENA_IN   = 1'b0;
    PSYNC_IN = 1'b0;
    TICK     = 1'b0;
    RST      = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_data", 0, 32'(DATA_OUT), 32'h00);
    check("rst_ena", 0, 32'(ENA_OUT), 32'h0);
    check("rst_psync", 0, 32'(PSYNC_OUT), 32'h0);
    check("rst_pkt_count", 0, 32'(pkt_count), 32'h0);
    check("rst_ovf_count", 0, 32'(ovf_count), 32'h0);
    check("rst_state", 0, 32'(state_mon), 32'h0);
    RST = 1'b0;

    // 1: no input -> two null packets, 2-cycle latency, steady cadence.
    @(posedge CLK); #1;
    TICK = 1'b1;
    @(posedge CLK); #1;
    TICK = 1'b0;
    check("lat_early_ena", 0, 32'(ENA_OUT), 32'h0);
    @(posedge CLK); #1;
    check("lat_ena", 0, 32'(ENA_OUT), 32'h1);
    check("lat_psync", 0, 32'(PSYNC_OUT), 32'h1);
    check("lat_data", 0, 32'(DATA_OUT), 32'h47);
    @(posedge CLK);
    run_ticks(375);
    check("t1_size", 0, 32'(out_q.size()), 32'd376);
    check_pkt("t1_null0", 0, -1);
    check_pkt("t1_null1", 188, -1);
    for (int i = 1; i < out_q.size(); i++) begin
      check("t1_cadence", i, 32'(out_q[i].c - out_q[i-1].c), 32'd4);
    end
    check("t1_state", 0, 32'(state_mon), 32'h0);
    out_q.delete();

    // 2: a packet written while a null packet is being read out.
    fork
      run_ticks(376);
      begin
        repeat (40) @(posedge CLK);
        send_pkt(0, 188);
        repeat (2) @(posedge CLK);
        #1;
        check("t2_cnt_written", 0, 32'(pkt_count), 32'd1);
      end
    join
    check("t2_size", 0, 32'(out_q.size()), 32'd376);
    check_pkt("t2_null", 0, -1);
    check_pkt("t2_pkt0", 188, 0);
    check("t2_cnt_drained", 0, 32'(pkt_count), 32'd0);
    out_q.delete();

    // 3: six packets with TICK stopped -> four kept (ring wraps), two dropped.
    for (int t = 1; t <= 6; t++) begin
      send_pkt(t, 188);
    end
    repeat (2) @(posedge CLK);
    #1;
    check("t3_cnt_full", 0, 32'(pkt_count), 32'd4);
    check("t3_ovf", 0, 32'(ovf_count), 32'd2);
    run_ticks(940);
    check("t3_size", 0, 32'(out_q.size()), 32'd940);
    check_pkt("t3_pkt1", 0, 1);
    check_pkt("t3_pkt2", 188, 2);
    check_pkt("t3_pkt3", 376, 3);
    check_pkt("t3_pkt4", 564, 4);
    check_pkt("t3_null", 752, -1);
    check("t3_cnt_drained", 0, 32'(pkt_count), 32'd0);
    out_q.delete();

    // 4: sync at byte 100 discards the partial packet; next packet kept intact.
    send_pkt(7, 100);
    send_pkt(8, 188);
    repeat (2) @(posedge CLK);
    #1;
    check("t4_cnt", 0, 32'(pkt_count), 32'd1);
    check("t4_ovf", 0, 32'(ovf_count), 32'd2);
    run_ticks(376);
    check("t4_size", 0, 32'(out_q.size()), 32'd376);
    check_pkt("t4_pkt8", 0, 8);
    check_pkt("t4_null", 188, -1);
    out_q.delete();

    // 5: enabled bytes (including 0x47) without PSYNC_IN are ignored.
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      DATA_IN  = (i % 2 == 1) ? 8'h47 : 8'hAA;
      ENA_IN   = 1'b1;
      PSYNC_IN = 1'b0;
    end
    @(posedge CLK); #1;
    ENA_IN = 1'b0;
    check("t5_cnt", 0, 32'(pkt_count), 32'd0);
    run_ticks(188);
    check("t5_size", 0, 32'(out_q.size()), 32'd188);
    check_pkt("t5_null", 0, -1);
    out_q.delete();

    // 6: reset while byte 50 of a packet is on the output.
    send_pkt(9, 188);
    send_pkt(10, 188);
    repeat (2) @(posedge CLK);
    #1;
    check("t6_cnt_two", 0, 32'(pkt_count), 32'd2);
    run_ticks(50);
    check("t6_cnt_one", 0, 32'(pkt_count), 32'd1);
    check("t6_state_pkt", 0, 32'(state_mon), 32'd1);
    check("t6_size", 0, 32'(out_q.size()), 32'd50);
    check_pkt("t6_pkt9", 0, 9);
    @(posedge CLK); #1;
    TICK = 1'b1;
    @(posedge CLK); #1;
    TICK = 1'b0;
    @(posedge CLK); #1;
    check("t6_b50_ena", 50, 32'(ENA_OUT), 32'h1);
    check("t6_b50_data", 50, 32'(DATA_OUT), 32'(pkt_byte(9, 50)));
    RST = 1'b1;
    #1;
    check("t6_rst_ena", 0, 32'(ENA_OUT), 32'h0);
    check("t6_rst_data", 0, 32'(DATA_OUT), 32'h00);
    check("t6_rst_state", 0, 32'(state_mon), 32'h0);
    check("t6_rst_cnt", 0, 32'(pkt_count), 32'h0);
    check("t6_rst_ovf", 0, 32'(ovf_count), 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    out_q.delete();
    run_ticks(188);
    check("t6_size_after", 0, 32'(out_q.size()), 32'd188);
    check_pkt("t6_null", 0, -1);
    check("t6_cnt_after", 0, 32'(pkt_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
